sprite_reader: RTL and testbench

Read side of the on-chip sprite ROMs. It takes the current VGA beam coordinates and the sprite position, and generates ROM read addresses. It absorbs the ROM's 1-cycle registered read latency and outputs a pipelined palette index plus a sprite_on flag to the color mapper. It also sequences animation frames stored back-to-back in one ROM, and latches sprite position and frame only at frame start so a sprite never tears mid-frame.

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_frame_ctr.sv | 68 ++++++
 rtl/sprite_reader.sv | 143 ++++++++++++++
 tb/tb_sprite_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Sprite constants and types shared by the sprite read path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_pkg;

  // Per-sprite geometry for the "patrick" sprite ROM
  localparam int PATRICK_W      = 70;
  localparam int PATRICK_H      = 70;
  localparam int PATRICK_FRAMES = 1;

  // Palette and screen geometry
  localparam int PAL_W           = 5;
  localparam int TRANSPARENT_IDX = 0;
  localparam int COORD_W         = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PAL_W-1:0]   pal_idx_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_frame_ctr.sv
// Shadow sprite position/flip plus animation frame sequencing, all updated only on frame_start.
// Latency: new values visible the cycle after the frame_start edge.
// Backpressure: none; frame_start is a free-running pulse.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_frame_start         one-cycle pulse at vertical sync
//   i_spr_x/i_spr_y/i_flip_h  requested position and mirror
//   o_x_s/o_y_s/o_flip_s  position and mirror held for the whole frame
//   o_frame_idx           current animation frame
module sprite_frame_ctr
  import sprite_pkg::*;
#(
  parameter int COORD_W     = sprite_pkg::COORD_W,
  parameter int NUM_FRAMES  = 1,
  parameter int FRAME_TICKS = 8,
  parameter int FIDX_W      = cnt_w(NUM_FRAMES)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_start,
  input  logic [COORD_W-1:0] i_spr_x,
  input  logic [COORD_W-1:0] i_spr_y,
  input  logic               i_flip_h,
  output logic [COORD_W-1:0] o_x_s,
  output logic [COORD_W-1:0] o_y_s,
  output logic               o_flip_s,
  output logic [FIDX_W-1:0]  o_frame_idx
);

  localparam int TICK_W = cnt_w(FRAME_TICKS);
  localparam logic [TICK_W-1:0] L_TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [TICK_W-1:0] L_TICK_ONE   = TICK_W'(1);
  localparam logic [FIDX_W-1:0] L_FRAME_LAST = FIDX_W'(NUM_FRAMES - 1);
  localparam logic [FIDX_W-1:0] L_FRAME_ONE  = FIDX_W'(1);

  logic [COORD_W-1:0] r_x_s;
  logic [COORD_W-1:0] r_y_s;
  logic               r_flip_s;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [FIDX_W-1:0]  r_frame_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_x_s       <= '0;
      r_y_s       <= '0;
      r_flip_s    <= 1'b0;
      r_tick_cnt  <= '0;
      r_frame_idx <= '0;
    end else if (i_frame_start) begin
      r_x_s    <= i_spr_x;
      r_y_s    <= i_spr_y;
      r_flip_s <= i_flip_h;
      if (r_tick_cnt == L_TICK_LAST) begin
        r_tick_cnt  <= '0;
        r_frame_idx <= (r_frame_idx == L_FRAME_LAST) ? '0 : (r_frame_idx + L_FRAME_ONE);
      end else begin
        r_tick_cnt <= r_tick_cnt + L_TICK_ONE;
      end
    end
  end

  assign o_x_s       = r_x_s;
  assign o_y_s       = r_y_s;
  assign o_flip_s    = r_flip_s;
  assign o_frame_idx = r_frame_idx;

endmodule

// File: rtl/sprite_reader.sv
// Sprite ROM read side: beam coordinates -> ROM address -> palette index + sprite_on.
// Latency: 3 edges from pixel sample to output (address reg, ROM reg, output reg); 1 pixel/cycle.
// Backpressure: none; fixed non-stalling pipeline, pix_valid=0 travels as a bubble.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-low reset
//   frame_start                vsync pulse; latches SprX/SprY/flip_h and steps animation
//   pix_valid, DrawX, DrawY    beam pixel
//   SprX, SprY, flip_h         requested sprite placement
//   rom_addr / rom_data        ROM interface (data valid one cycle after address)
//   pix_out_valid, sprite_on, color_idx  to color mapper
module sprite_reader
  import sprite_pkg::*;
#(
  parameter int SPR_W       = PATRICK_W,
  parameter int SPR_H       = PATRICK_H,
  parameter int NUM_FRAMES  = PATRICK_FRAMES,
  parameter int FRAME_TICKS = 8,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = PAL_W,
  parameter int COORD_W     = sprite_pkg::COORD_W,
  parameter int TRANSPARENT = TRANSPARENT_IDX
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic [COORD_W-1:0] SprX,
  input  logic [COORD_W-1:0] SprY,
  input  logic               flip_h,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic               pix_out_valid,
  output logic               sprite_on,
  output logic [DATA_W-1:0]  color_idx
);

  localparam int FIDX_W = cnt_w(NUM_FRAMES);

  // All frames must fit in the ROM address space
  if (NUM_FRAMES * SPR_W * SPR_H > 2 ** ADDR_W) begin : g_rom_too_small
    $error("sprite_reader: NUM_FRAMES*SPR_W*SPR_H exceeds 2**ADDR_W");
  end

  // Coordinates are compared one bit wider so x_s+SPR_W never wraps
  localparam logic [COORD_W:0]  L_W_C     = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0]  L_H_C     = (COORD_W+1)'(SPR_H);
  localparam logic [COORD_W:0]  L_W_M1_C  = (COORD_W+1)'(SPR_W - 1);
  localparam logic [ADDR_W-1:0] L_W_A     = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] L_FRAME_A = ADDR_W'(SPR_W * SPR_H);
  localparam logic [DATA_W-1:0] L_TRANSP  = DATA_W'(TRANSPARENT);

  logic [COORD_W-1:0] w_x_s;
  logic [COORD_W-1:0] w_y_s;
  logic               w_flip_s;
  logic [FIDX_W-1:0]  w_frame_idx;

  logic [COORD_W:0]   w_px;
  logic [COORD_W:0]   w_py;
  logic [COORD_W:0]   w_sx;
  logic [COORD_W:0]   w_sy;
  logic [COORD_W:0]   w_dx;
  logic [COORD_W:0]   w_dy;
  logic [COORD_W:0]   w_col;
  logic               w_hit;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_on;

  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_s1_valid;
  logic               r_s1_hit;
  logic               r_s2_valid;
  logic               r_s2_hit;
  logic               r_pix_out_valid;
  logic               r_sprite_on;
  logic [DATA_W-1:0]  r_color_idx;

  sprite_frame_ctr #(
    .COORD_W     (COORD_W),
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_TICKS (FRAME_TICKS),
    .FIDX_W      (FIDX_W)
  ) u_frame_ctr (
    .i_clk         (Clk),
    .i_rst_n       (Reset),
    .i_frame_start (frame_start),
    .i_spr_x       (SprX),
    .i_spr_y       (SprY),
    .i_flip_h      (flip_h),
    .o_x_s         (w_x_s),
    .o_y_s         (w_y_s),
    .o_flip_s      (w_flip_s),
    .o_frame_idx   (w_frame_idx)
  );

  // Hit test and address use the shadow values, so a pixel that coincides
  // with frame_start still sees the previous frame's placement.
  assign w_px  = {1'b0, DrawX};
  assign w_py  = {1'b0, DrawY};
  assign w_sx  = {1'b0, w_x_s};
  assign w_sy  = {1'b0, w_y_s};
  assign w_hit = (w_px >= w_sx) && (w_px < (w_sx + L_W_C)) &&
                 (w_py >= w_sy) && (w_py < (w_sy + L_H_C));
  assign w_dx  = w_px - w_sx;
  assign w_dy  = w_py - w_sy;
  assign w_col = w_flip_s ? (L_W_M1_C - w_dx) : w_dx;

  // Frames are stored back-to-back; arithmetic is modulo 2**ADDR_W
  assign w_addr = (ADDR_W'(w_frame_idx) * L_FRAME_A) + (ADDR_W'(w_dy) * L_W_A) + ADDR_W'(w_col);

  // rom_data lines up with the stage-2 bits: both were launched by the same address edge
  assign w_on = r_s2_valid && r_s2_hit && (rom_data != L_TRANSP);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_rom_addr      <= '0;
      r_s1_valid      <= 1'b0;
      r_s1_hit        <= 1'b0;
      r_s2_valid      <= 1'b0;
      r_s2_hit        <= 1'b0;
      r_pix_out_valid <= 1'b0;
      r_sprite_on     <= 1'b0;
      r_color_idx     <= '0;
    end else begin
      r_rom_addr      <= w_hit ? w_addr : '0;
      r_s1_valid      <= pix_valid;
      r_s1_hit        <= w_hit;
      r_s2_valid      <= r_s1_valid;
      r_s2_hit        <= r_s1_hit;
      r_pix_out_valid <= r_s2_valid;
      r_sprite_on     <= w_on;
      r_color_idx     <= w_on ? rom_data : '0;
    end
  end

  assign rom_addr      = r_rom_addr;
  assign pix_out_valid = r_pix_out_valid;
  assign sprite_on     = r_sprite_on;
  assign color_idx     = r_color_idx;

endmodule

// File: tb/tb_sprite_reader.sv
module tb_sprite_reader;

  localparam int SW = 70;
  localparam int SH = 70;

  typedef struct {
    bit v;
    bit on;
    int idx;
    int addr;
  } exp_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic        flip_h = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [9:0]  SprX = '0;
  logic [9:0]  SprY = '0;

  logic [12:0] rom_addr_a;
  logic [13:0] rom_addr_b;
  logic [4:0]  rom_data_a;
  logic [4:0]  rom_data_b;
  logic [4:0]  color_idx_a;
  logic [4:0]  color_idx_b;
  logic        pov_a, pov_b, on_a, on_b;

  // Default configuration
  sprite_reader u_dut_a (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .SprX          (SprX),
    .SprY          (SprY),
    .flip_h        (flip_h),
    .rom_addr      (rom_addr_a),
    .rom_data      (rom_data_a),
    .pix_out_valid (pov_a),
    .sprite_on     (on_a),
    .color_idx     (color_idx_a)
  );

  // Two-frame animation; ROM widened so both frames fit
  sprite_reader #(
    .NUM_FRAMES  (2),
    .FRAME_TICKS (2),
    .ADDR_W      (14)
  ) u_dut_b (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .SprX          (SprX),
    .SprY          (SprY),
    .flip_h        (flip_h),
    .rom_addr      (rom_addr_b),
    .rom_data      (rom_data_b),
    .pix_out_valid (pov_b),
    .sprite_on     (on_b),
    .color_idx     (color_idx_b)
  );

  // ROMs with registered read; content is the low 5 address bits
  always @(posedge Clk) begin
    rom_data_a <= rom_addr_a[4:0];
    rom_data_b <= rom_addr_b[4:0];
  end

  int checks = 0;
  int failures = 0;

  // Reference state per configuration: index 0 = dut_a, 1 = dut_b
  int   xs[2];
  int   ys[2];
  int   flp[2];
  int   tick[2];
  int   fidx[2];
  int   nfr[2]  = '{1, 2};
  int   fts[2]  = '{8, 2};
  int   amod[2] = '{8192, 16384};
  exp_t pipe[2][2];
  exp_t cur[2];
  exp_t outq[2];
  exp_t zero_e = '{0, 0, 0, 0};

  function automatic exp_t model_pix(input int d, input bit pv, input int dx, input int dy);
    exp_t e;
    bit   hit;
    int   col;
    int   row;
    int   a;
    hit = (dx >= xs[d]) && (dx < xs[d] + SW) && (dy >= ys[d]) && (dy < ys[d] + SH);
    col = (flp[d] != 0) ? (SW - 1 - (dx - xs[d])) : (dx - xs[d]);
    row = dy - ys[d];
    a   = hit ? ((fidx[d] * SW * SH + row * SW + col) % amod[d]) : 0;
    e.addr = a;
    e.v    = pv;
    e.on   = pv && hit && ((a % 32) != 0);
    e.idx  = e.on ? (a % 32) : 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference at the edge, then compare
  task automatic cycle(input bit rst, input bit fs, input bit pv, input int dx, input int dy,
                       input int sx, input int sy, input bit fl);
    Reset       = rst;
    frame_start = fs;
    pix_valid   = pv;
    DrawX       = dx[9:0];
    DrawY       = dy[9:0];
    SprX        = sx[9:0];
    SprY        = sy[9:0];
    flip_h      = fl;
    @(posedge Clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        xs[d] = 0; ys[d] = 0; flp[d] = 0; tick[d] = 0; fidx[d] = 0;
        pipe[d][0] = zero_e; pipe[d][1] = zero_e;
        cur[d] = zero_e; outq[d] = zero_e;
      end else begin
        cur[d]     = model_pix(d, pv, dx, dy);
        outq[d]    = pipe[d][1];
        pipe[d][1] = pipe[d][0];
        pipe[d][0] = cur[d];
        if (fs) begin
          xs[d] = sx; ys[d] = sy; flp[d] = fl;
          tick[d]++;
          if (tick[d] == fts[d]) begin
            tick[d] = 0;
            fidx[d] = (fidx[d] + 1) % nfr[d];
          end
        end
      end
    end
    #1;
    chk("a_valid", 32'(pov_a), 32'(outq[0].v));
    chk("a_on", 32'(on_a), 32'(outq[0].on));
    chk("a_color", 32'(color_idx_a), outq[0].idx);
    chk("b_valid", 32'(pov_b), 32'(outq[1].v));
    chk("b_on", 32'(on_b), 32'(outq[1].on));
    chk("b_color", 32'(color_idx_b), outq[1].idx);
    if (pv || !rst) begin
      chk("a_addr", 32'(rom_addr_a), cur[0].addr);
      chk("b_addr", 32'(rom_addr_b), cur[1].addr);
    end
  endtask

  initial begin
    bit fs;
    bit pv;
    bit fl;
    int sx, sy, dx, dy;

    for (int d = 0; d < 2; d++) begin
      xs[d] = 0; ys[d] = 0; flp[d] = 0; tick[d] = 0; fidx[d] = 0;
      pipe[d][0] = zero_e; pipe[d][1] = zero_e;
    end

    // Reset held two cycles while frame_start/pix_valid toggle
    cycle(0, 1, 1, 100, 50, 100, 50, 0);
    cycle(0, 0, 1, 120, 60, 100, 50, 0);
    chk("rst_addr", 32'(rom_addr_a), 0);
    chk("rst_valid", 32'(pov_a), 0);

    // Latch sprite at (100,50)
    cycle(1, 1, 0, 0, 0, 100, 50, 0);

    // Corners and surrounding misses
    cycle(1, 0, 1, 100, 50, 100, 50, 0);
    chk("corner_tl_addr", 32'(rom_addr_a), 0);
    cycle(1, 0, 1, 169, 119, 100, 50, 0);
    chk("corner_br_addr", 32'(rom_addr_a), 4899);
    cycle(1, 0, 1, 99, 50, 100, 50, 0);
    chk("miss_left_addr", 32'(rom_addr_a), 0);
    chk("transp_on", 32'(on_a), 0);
    chk("transp_color", 32'(color_idx_a), 0);
    chk("transp_valid", 32'(pov_a), 1);
    cycle(1, 0, 1, 170, 50, 100, 50, 0);
    chk("miss_right_addr", 32'(rom_addr_a), 0);
    chk("br_on", 32'(on_a), 1);
    chk("br_color", 32'(color_idx_a), 3);
    cycle(1, 0, 1, 100, 49, 100, 50, 0);
    cycle(1, 0, 1, 100, 120, 100, 50, 0);
    cycle(1, 0, 0, 0, 0, 100, 50, 0);
    chk("miss_on", 32'(on_a), 0);
    chk("miss_valid", 32'(pov_a), 1);
    cycle(1, 0, 0, 0, 0, 100, 50, 0);

    // Horizontal flip
    cycle(1, 1, 0, 0, 0, 100, 50, 1);
    cycle(1, 0, 1, 100, 51, 100, 50, 1);
    chk("flip_addr", 32'(rom_addr_a), 139);
    chk("flip_addr_f1", 32'(rom_addr_b), 5039);
    cycle(1, 0, 0, 0, 0, 100, 50, 1);
    cycle(1, 0, 0, 0, 0, 100, 50, 1);

    // Animation sequencing from a fresh reset; frame_idx 0,1,1,0
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 100, 50, 0);
    cycle(1, 0, 1, 100, 50, 100, 50, 0);
    chk("anim1", 32'(rom_addr_b), 0);
    cycle(1, 1, 1, 100, 50, 100, 50, 0);
    chk("anim_coinc2", 32'(rom_addr_b), 0);
    cycle(1, 0, 1, 100, 50, 100, 50, 0);
    chk("anim2", 32'(rom_addr_b), 4900);
    cycle(1, 1, 1, 100, 50, 100, 50, 0);
    chk("anim_coinc3", 32'(rom_addr_b), 4900);
    cycle(1, 0, 1, 100, 50, 100, 50, 0);
    chk("anim3", 32'(rom_addr_b), 4900);
    cycle(1, 1, 1, 100, 50, 100, 50, 0);
    chk("anim_coinc4", 32'(rom_addr_b), 4900);
    cycle(1, 0, 1, 100, 50, 100, 50, 0);
    chk("anim4", 32'(rom_addr_b), 0);

    // Position change without frame_start must not take effect
    cycle(1, 0, 1, 101, 50, 300, 200, 0);
    chk("no_tear_addr", 32'(rom_addr_a), 1);
    cycle(1, 1, 0, 0, 0, 300, 200, 0);
    cycle(1, 0, 1, 301, 200, 300, 200, 0);
    chk("new_pos_addr", 32'(rom_addr_a), 1);

    // Reset with two pixels in flight
    cycle(1, 0, 1, 310, 210, 300, 200, 0);
    cycle(1, 0, 1, 311, 210, 300, 200, 0);
    cycle(0, 0, 0, 0, 0, 300, 200, 0);
    chk("flush_valid0", 32'(pov_a), 0);
    cycle(1, 1, 0, 0, 0, 100, 50, 0);
    chk("flush_valid1", 32'(pov_a), 0);
    cycle(1, 0, 0, 0, 0, 100, 50, 0);

    // Randomized traffic clustered around the current sprite box
    for (int i = 0; i < 800; i++) begin
      fs = ($urandom_range(0, 24) == 0);
      pv = ($urandom_range(0, 4) != 0);
      fl = 1'($urandom_range(0, 1));
      sx = int'($urandom_range(0, 1023));
      sy = int'($urandom_range(0, 1023));
      dx = (xs[0] + int'($urandom_range(0, 80)) - 5) & 1023;
      dy = (ys[0] + int'($urandom_range(0, 80)) - 5) & 1023;
      cycle(1, fs, pv, dx, dy, sx, sy, fl);
    end
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
